// File: rtl/udma_uart_rx_ovs.sv
// 16x oversampled UART receiver with majority-vote sampling, configurable framing,
// break/frame/parity/idle-timeout detection and a first-word-fall-through byte FIFO.
module udma_uart_rx_ovs #(
  parameter int FIFO_DEPTH    = 8,
  parameter int DIV_WIDTH     = 16,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_i,
  input  logic                          cfg_en_i,
  input  logic [DIV_WIDTH-1:0]          cfg_div_i,
  input  logic [1:0]                    cfg_bits_i,
  input  logic [2:0]                    cfg_parity_i,
  input  logic                          cfg_stop_bits_i,
  input  logic [TIMEOUT_WIDTH-1:0]      cfg_timeout_i,
  input  logic                          cfg_clr_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          busy_o,
  output logic                          char_event_o,
  output logic                          err_parity_o,
  output logic                          err_frame_o,
  output logic                          err_overflow_o,
  output logic                          break_o,
  output logic                          timeout_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = TIMEOUT_WIDTH + 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2, BRK_WAIT} state_e;

  logic                 rx_s1_q, rx_s2_q, rx_last_q;
  logic                 samp7_q, samp7_d, samp8_q, samp8_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  state_e               state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           data_q, data_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop1_bad_q, stop1_bad_d;
  logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
  logic                 to_fired_q, to_fired_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        count_q, count_d;
  logic [7:0]           mem_q [0:FIFO_DEPTH-1];
  logic                 char_ev_q, char_ev_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                 ovf_q, ovf_d, brk_q, brk_d, to_q, to_d;

  logic       tick, mid, vote, start_edge;
  logic       resolve, stop_bad, push_req, par_exp;
  logic       pop, push, full;
  logic [2:0] last_bit;

  assign tick       = (div_cnt_q >= cfg_div_i);
  assign mid        = tick && (tick_cnt_q == 4'd9);
  assign vote       = (samp7_q & samp8_q) | (samp7_q & rx_s2_q) | (samp8_q & rx_s2_q);
  assign start_edge = cfg_en_i && (state_q == IDLE) && rx_last_q && !rx_s2_q;
  assign last_bit   = {1'b0, cfg_bits_i} + 3'd4;

  // Oversample timing free-runs, but is re-phased on every start edge.
  always_comb begin
    div_cnt_d  = (start_edge || tick) ? '0 : div_cnt_q + DIV_WIDTH'(1);
    tick_cnt_d = start_edge ? 4'd0 : (tick ? tick_cnt_q + 4'd1 : tick_cnt_q);
    samp7_d    = (tick && tick_cnt_q == 4'd7) ? rx_s2_q : samp7_q;
    samp8_d    = (tick && tick_cnt_q == 4'd8) ? rx_s2_q : samp8_q;
  end

  always_comb begin
    case (cfg_parity_i[1:0])
      2'b00:   par_exp = ^data_q;
      2'b01:   par_exp = ~^data_q;
      2'b10:   par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    par_bit_d   = par_bit_q;
    stop1_bad_d = stop1_bad_q;
    resolve     = 1'b0;
    stop_bad    = 1'b0;
    case (state_q)
      IDLE: if (start_edge) begin
        state_d     = START;
        bit_cnt_d   = '0;
        data_d      = '0;
        par_bit_d   = 1'b0;
        stop1_bad_d = 1'b0;
      end
      START: if (mid) state_d = vote ? IDLE : DATA;
      DATA: if (mid) begin
        data_d[bit_cnt_q] = vote;
        if (bit_cnt_q == last_bit) state_d = cfg_parity_i[2] ? PARITY : STOP;
        else                       bit_cnt_d = bit_cnt_q + 3'd1;
      end
      PARITY: if (mid) begin
        par_bit_d = vote;
        state_d   = STOP;
      end
      STOP: if (mid) begin
        if (cfg_stop_bits_i) begin
          stop1_bad_d = ~vote;
          state_d     = STOP2;
        end else begin
          resolve  = 1'b1;
          stop_bad = ~vote;
        end
      end
      STOP2: if (mid) begin
        resolve  = 1'b1;
        stop_bad = stop1_bad_q | ~vote;
      end
      BRK_WAIT: if (rx_s2_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (resolve) state_d = stop_bad ? BRK_WAIT : IDLE;
    if (!cfg_en_i) begin
      state_d = IDLE;
      resolve = 1'b0;
    end
  end

  always_comb begin
    push_req  = resolve && !stop_bad;
    brk_d     = resolve && stop_bad && (data_q == 8'h00) && !(cfg_parity_i[2] && par_bit_q);
    ferr_d    = resolve && stop_bad && !brk_d;
    perr_d    = push_req && cfg_parity_i[2] && (par_bit_q != par_exp);
    char_ev_d = push_req;
    full      = (count_q == LW'(FIFO_DEPTH));
    pop       = (count_q != '0) && rx_ready_i && !cfg_clr_i;
    push      = push_req && !cfg_clr_i && (!full || pop);
    ovf_d     = push_req && !cfg_clr_i && full && !pop;
    if (cfg_clr_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + LW'(push) - LW'(pop);
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    end
  end

  // Idle timer counts ticks while idle with data waiting; fires once per idle stretch.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    to_fired_d = to_fired_q;
    to_d       = 1'b0;
    if (state_q != IDLE || count_q == '0 || start_edge) begin
      idle_cnt_d = '0;
      to_fired_d = 1'b0;
    end else if (tick && !to_fired_q && cfg_timeout_i != '0) begin
      idle_cnt_d = idle_cnt_q + IW'(1);
      if (idle_cnt_d == {cfg_timeout_i, 4'b0000}) begin
        to_d       = 1'b1;
        to_fired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_last_q   <= 1'b1;
      samp7_q     <= 1'b1;
      samp8_q     <= 1'b1;
      div_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      par_bit_q   <= 1'b0;
      stop1_bad_q <= 1'b0;
      idle_cnt_q  <= '0;
      to_fired_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      char_ev_q   <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovf_q       <= 1'b0;
      brk_q       <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      rx_s1_q     <= rx_i;
      rx_s2_q     <= rx_s1_q;
      rx_last_q   <= rx_s2_q;
      samp7_q     <= samp7_d;
      samp8_q     <= samp8_d;
      div_cnt_q   <= div_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      par_bit_q   <= par_bit_d;
      stop1_bad_q <= stop1_bad_d;
      idle_cnt_q  <= idle_cnt_d;
      to_fired_q  <= to_fired_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      char_ev_q   <= char_ev_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovf_q       <= ovf_d;
      brk_q       <= brk_d;
      to_q        <= to_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_q;
  end

  assign rx_valid_o     = (count_q != '0);
  assign rx_data_o      = rx_valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_level_o   = count_q;
  assign busy_o         = (state_q != IDLE);
  assign char_event_o   = char_ev_q;
  assign err_parity_o   = perr_q;
  assign err_frame_o    = ferr_q;
  assign err_overflow_o = ovf_q;
  assign break_o        = brk_q;
  assign timeout_o      = to_q;
endmodule

// File: tb/tb_udma_uart_rx_ovs.sv
// Scoreboard bench for udma_uart_rx_ovs: frames are built from framing rules, expected
// bytes queued at send time and compared by a monitor whenever the FIFO is popped.
module tb_udma_uart_rx_ovs;
  logic        clk = 1'b0, rst = 1'b1, rx = 1'b1, en = 1'b0, clr = 1'b0, rdy = 1'b0;
  logic        stop2 = 1'b0;
  logic [15:0] div = '0;
  logic [1:0]  bits = 2'd3;
  logic [2:0]  par = 3'd0;
  logic [7:0]  tmo = '0;
  logic [7:0]  rx_data;
  logic [3:0]  level;
  logic        rx_valid, busy, char_ev, perr, ferr, ovf, brk, tout;

  udma_uart_rx_ovs #(.FIFO_DEPTH(8), .DIV_WIDTH(16), .TIMEOUT_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx), .cfg_en_i(en), .cfg_div_i(div),
    .cfg_bits_i(bits), .cfg_parity_i(par), .cfg_stop_bits_i(stop2),
    .cfg_timeout_i(tmo), .cfg_clr_i(clr), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .rx_ready_i(rdy), .fifo_level_o(level), .busy_o(busy), .char_event_o(char_ev),
    .err_parity_o(perr), .err_frame_o(ferr), .err_overflow_o(ovf), .break_o(brk),
    .timeout_o(tout));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int n_char = 0, n_perr = 0, n_ferr = 0, n_ovf = 0, n_brk = 0, n_to = 0;
  int t_char = 0, t_to = 0, t_edge = 0;
  int rdy_mode = 0;
  logic [7:0] exp_q[$];

  task automatic check(string name, longint got, longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic check_rng(string name, longint got, longint lo, longint hi);
    n_chk++;
    if (got >= lo && got <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ready driver: 0 = hold low, 1 = hold high, 2 = random.
  initial forever begin
    @(posedge clk);
    #2;
    rdy = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (char_ev) begin n_char++; t_char = cyc; end
      if (perr) n_perr++;
      if (ferr) n_ferr++;
      if (ovf)  n_ovf++;
      if (brk)  n_brk++;
      if (tout) begin n_to++; t_to = cyc; end
      if (rx_valid && rdy) begin
        if (exp_q.size() == 0) check("unexpected_pop", rx_data, -1);
        else check("rx_data", rx_data, exp_q.pop_front());
      end
    end
  end

  function automatic logic par_bit(logic [7:0] d, logic [2:0] mode);
    case (mode[1:0])
      2'b00:   return ^d;
      2'b01:   return ~^d;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic send_raw(logic [15:0] pat, int n);
    for (int i = 0; i < n; i++) begin
      rx = pat[i];
      if (i == 0) t_edge = cyc;
      step(16 * (int'(div) + 1));
    end
  endtask

  task automatic send_frame(logic [7:0] d_in, bit bad_par, bit expect_push);
    int n = int'(bits) + 5;
    int idx = 0;
    logic [15:0] pat = '0;
    logic [7:0] d = d_in & 8'((1 << n) - 1);
    idx = 1;
    for (int i = 0; i < n; i++) begin pat[idx] = d[i]; idx = idx + 1; end
    if (par[2]) begin pat[idx] = par_bit(d, par) ^ bad_par; idx = idx + 1; end
    for (int i = 0; i < (stop2 ? 3 : 2); i++) begin pat[idx] = 1'b1; idx = idx + 1; end
    if (expect_push) exp_q.push_back(d);
    send_raw(pat, idx);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !rx_valid) break;
      step(1);
    end
    check("drain", exp_q.size() + int'(rx_valid), 0);
  endtask

  initial begin
    int c0, p0, f0, b0, o0, t0, pexp, cexp;
    step(3);
    check("rst_valid", rx_valid, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_data", rx_data, 0);
    check("rst_pulses", {char_ev, perr, ferr, ovf, brk, tout}, 0);
    rst = 1'b0;
    step(2);
    en = 1'b1;

    // 8N1 0xA5 at div=0: latency, single event, level 1
    c0 = n_char;
    send_frame(8'hA5, 1'b0, 1'b1);
    check_rng("latency_clks", t_char - t_edge, 150, 162);
    check("a5_events", n_char - c0, 1);
    check("a5_level", level, 1);
    check("a5_head", rx_data, 8'hA5);
    rdy_mode = 1;
    wait_drain();

    // 5 bits, odd parity, 2 stop, corrupted parity
    bits = 2'd0; par = 3'b101; stop2 = 1'b1;
    p0 = n_perr;
    send_frame(8'h15, 1'b1, 1'b1);
    check("bad_parity_pulse", n_perr - p0, 1);
    wait_drain();
    bits = 2'd3; par = 3'b000; stop2 = 1'b0;

    // glitch shorter than half a bit
    c0 = n_char; f0 = n_ferr; b0 = n_brk;
    rx = 1'b0; step(4); rx = 1'b1; step(2);
    check("glitch_busy_hi", busy, 1);
    step(20);
    check("glitch_busy_lo", busy, 0);
    check("glitch_pulses", (n_char - c0) + (n_ferr - f0) + (n_brk - b0), 0);
    check("glitch_level", level, 0);

    // break: line low 20 bit times
    c0 = n_char; f0 = n_ferr; b0 = n_brk;
    rx = 1'b0; step(20 * 16);
    check("brk_busy_held", busy, 1);
    rx = 1'b1; step(6);
    check("brk_busy_lo", busy, 0);
    check("brk_pulse", n_brk - b0, 1);
    check("brk_no_ferr", n_ferr - f0, 0);
    check("brk_no_char", n_char - c0, 0);

    // framing error: non-zero data, stop bit low
    c0 = n_char; f0 = n_ferr; b0 = n_brk;
    send_raw(16'h0C00 | (16'h5A << 1), 12);
    check("ferr_pulse", n_ferr - f0, 1);
    check("ferr_no_brk", n_brk - b0, 0);
    check("ferr_no_char", n_char - c0, 0);
    check("ferr_busy", busy, 0);

    // disable mid-frame
    c0 = n_char; f0 = n_ferr;
    fork
      send_frame(8'h33, 1'b0, 1'b0);
      begin step(60); en = 1'b0; step(2); check("dis_busy", busy, 0); end
    join
    en = 1'b1; step(16);
    check("dis_pulses", (n_char - c0) + (n_ferr - f0), 0);
    check("dis_level", level, 0);

    // flush
    rdy_mode = 0; step(1);
    send_frame(8'h3C, 1'b0, 1'b1);
    check("clr_pre_level", level, 1);
    o0 = n_ovf;
    clr = 1'b1; step(1); clr = 1'b0;
    exp_q.delete();
    check("clr_level", level, 0);
    check("clr_valid", rx_valid, 0);

    // overflow: 9 chars into 8 entries
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b0, i < 8);
    check("ovf_level", level, 8);
    check("ovf_pulse", n_ovf - o0, 1);
    check("ovf_head", rx_data, 0);
    rdy_mode = 1;
    wait_drain();

    // idle timeout
    rdy_mode = 0; tmo = 8'd4; step(1);
    t0 = n_to;
    send_frame(8'h77, 1'b0, 1'b1);
    step(120);
    check("to_pulse", n_to - t0, 1);
    check_rng("to_delay", t_to - t_char, 62, 68);
    rdy_mode = 1;
    wait_drain();
    step(150);
    check("to_none_empty", n_to - t0, 1);
    tmo = 8'd0;

    // randomized framing
    rdy_mode = 2;
    c0 = n_char; p0 = n_perr; f0 = n_ferr; b0 = n_brk; o0 = n_ovf;
    pexp = 0; cexp = 0;
    for (int k = 0; k < 30; k++) begin
      bit bad;
      en = 1'b0; step(1);
      div   = 16'($urandom_range(0, 2));
      bits  = 2'($urandom);
      par   = 3'($urandom);
      stop2 = 1'($urandom);
      en = 1'b1; step(2);
      bad = par[2] ? 1'($urandom_range(0, 1)) : 1'b0;
      if (bad) pexp++;
      cexp++;
      send_frame(8'($urandom), bad, 1'b1);
    end
    rdy_mode = 1;
    wait_drain();
    check("rnd_chars", n_char - c0, cexp);
    check("rnd_perr", n_perr - p0, pexp);
    check("rnd_other", (n_ferr - f0) + (n_brk - b0) + (n_ovf - o0), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: got 1 expected 0");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end
endmodule
